// File: rtl/evt2_encoder.sv
// EVT2 transmit encoder: packs (x, y, polarity, timestamp) events into 32-bit EVT2 words,
// inserting TIME_HIGH words on upper-timestamp changes. Optional keep-alive: EVT2_ENC_HEARTBEAT_EN.
module evt2_encoder #(
    parameter int TS_BITS          = 34,
    parameter int HEARTBEAT_CYCLES = 12_000_000,
    parameter int CNT_BITS         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         in_x,
    input  logic [10:0]         in_y,
    input  logic                in_polarity,
    input  logic [TS_BITS-1:0]  in_timestamp,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [31:0]         out_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_BITS-1:0] cd_count,
    output logic [CNT_BITS-1:0] th_count,
    output logic [1:0]          debug_state
);

    if (TS_BITS < 7 || TS_BITS > 34) begin : g_bad_ts_bits
        $error("evt2_encoder: TS_BITS must lie in 7..34");
    end
    if (HEARTBEAT_CYCLES < 1) begin : g_bad_hb_cycles
        $error("evt2_encoder: HEARTBEAT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TH   = 2'd1,
        S_CD   = 2'd2,
        S_HB   = 2'd3
    } state_t;

    function automatic logic [31:0] th_word_f(input logic [27:0] th);
        return {4'h8, th};
    endfunction

    function automatic logic [31:0] cd_word_f(input logic        pol,
                                              input logic [5:0]  ts_lo,
                                              input logic [10:0] x,
                                              input logic [10:0] y);
        return {3'b000, pol, ts_lo, x, y};
    endfunction

    state_t                state_r;
    state_t                state_s;
    state_t                acc_state_s;
    logic [31:0]           out_word_r;
    logic [31:0]           word_s;
    logic [31:0]           acc_word_s;
    logic                  out_valid_r;
    logic [10:0]           hold_x_r;
    logic [10:0]           hold_y_r;
    logic                  hold_pol_r;
    logic [33:0]           hold_ts_r;
    logic [27:0]           last_th_r;
    logic                  th_seen_r;
    logic [CNT_BITS-1:0]   cd_count_r;
    logic [CNT_BITS-1:0]   th_count_r;
    logic [33:0]           in_ts_s;
    logic                  need_th_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  th_done_s;
    logic                  cd_done_s;
    logic                  hb_done_s;
    logic                  hb_fire_s;

    // Input acceptance: a new event can be taken when idle or when the pending CD word leaves this cycle.
    always_comb begin
        in_ready_s = (state_r == S_IDLE) || ((state_r == S_CD) && out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Acceptance rule: a TIME_HIGH word precedes the CD word whenever the upper time bits differ.
    always_comb begin
        in_ts_s   = 34'(in_timestamp);
        need_th_s = !th_seen_r || (in_ts_s[33:6] != last_th_r);
        if (need_th_s) begin
            acc_state_s = S_TH;
            acc_word_s  = th_word_f(in_ts_s[33:6]);
        end else begin
            acc_state_s = S_CD;
            acc_word_s  = cd_word_f(in_polarity, in_ts_s[5:0], in_x, in_y);
        end
    end

`ifdef EVT2_ENC_HEARTBEAT_EN
    localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    logic [HB_W-1:0] hb_cnt_r;

    assign hb_fire_s = (state_r == S_IDLE) && th_seen_r &&
                       (hb_cnt_r == HB_W'(HEARTBEAT_CYCLES - 1));

    // Idle counter: runs only while idle after the first TIME_HIGH; any other activity restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_r <= '0;
        end else if ((state_r == S_IDLE) && th_seen_r && !accept_s && !hb_fire_s) begin
            hb_cnt_r <= hb_cnt_r + HB_W'(1);
        end else begin
            hb_cnt_r <= '0;
        end
    end
`else
    assign hb_fire_s = 1'b0;
`endif

    // Next-state and next-word logic.
    always_comb begin
        state_s   = state_r;
        word_s    = out_word_r;
        th_done_s = 1'b0;
        cd_done_s = 1'b0;
        hb_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = acc_state_s;
                    word_s  = acc_word_s;
                end else if (hb_fire_s) begin
                    state_s = S_HB;
                    word_s  = th_word_f(last_th_r);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TH: begin
                if (out_ready) begin
                    th_done_s = 1'b1;
                    state_s   = S_CD;
                    word_s    = cd_word_f(hold_pol_r, hold_ts_r[5:0], hold_x_r, hold_y_r);
                end else begin
                    state_s = S_TH;
                end
            end
            S_CD: begin
                if (out_ready) begin
                    cd_done_s = 1'b1;
                    if (accept_s) begin
                        state_s = acc_state_s;
                        word_s  = acc_word_s;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_CD;
                end
            end
            S_HB: begin
                if (out_ready) begin
                    hb_done_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    state_s = S_HB;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output word registers; out_valid follows the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            out_word_r  <= 32'h0000_0000;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_word_r  <= word_s;
            out_valid_r <= (state_s != S_IDLE);
        end
    end

    // Event holding register, loaded on every acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_x_r   <= 11'd0;
            hold_y_r   <= 11'd0;
            hold_pol_r <= 1'b0;
            hold_ts_r  <= 34'd0;
        end else if (accept_s) begin
            hold_x_r   <= in_x;
            hold_y_r   <= in_y;
            hold_pol_r <= in_polarity;
            hold_ts_r  <= in_ts_s;
        end else begin
            hold_x_r   <= hold_x_r;
            hold_y_r   <= hold_y_r;
            hold_pol_r <= hold_pol_r;
            hold_ts_r  <= hold_ts_r;
        end
    end

    // Time-high tracking: updated only once the TIME_HIGH word has actually left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_th_r <= 28'd0;
            th_seen_r <= 1'b0;
        end else if (th_done_s) begin
            last_th_r <= hold_ts_r[33:6];
            th_seen_r <= 1'b1;
        end else begin
            last_th_r <= last_th_r;
            th_seen_r <= th_seen_r;
        end
    end

    // Statistics counters, wrapping, stepped on completed handshakes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_count_r <= '0;
            th_count_r <= '0;
        end else begin
            if (cd_done_s) begin
                cd_count_r <= cd_count_r + CNT_BITS'(1);
            end else begin
                cd_count_r <= cd_count_r;
            end
            if (th_done_s || hb_done_s) begin
                th_count_r <= th_count_r + CNT_BITS'(1);
            end else begin
                th_count_r <= th_count_r;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_word    = out_word_r;
    assign out_valid   = out_valid_r;
    assign cd_count    = cd_count_r;
    assign th_count    = th_count_r;
    assign debug_state = state_r;

endmodule

// File: tb/tb_evt2_encoder.sv
// Self-checking bench for evt2_encoder: directed scenarios plus randomized events with random
// backpressure, checked against a word-queue reference model built from the EVT2 format rules.
`timescale 1ns/1ps
module tb_evt2_encoder;

    localparam int TS_BITS   = 34;
    localparam int CNT_BITS  = 16;
    localparam int HB_CYCLES = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [10:0]         in_x;
    logic [10:0]         in_y;
    logic                in_polarity;
    logic [TS_BITS-1:0]  in_timestamp;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         out_word;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_BITS-1:0] cd_count;
    logic [CNT_BITS-1:0] th_count;
    logic [1:0]          debug_state;

    evt2_encoder #(
        .TS_BITS          (TS_BITS),
        .HEARTBEAT_CYCLES (HB_CYCLES),
        .CNT_BITS         (CNT_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_polarity  (in_polarity),
        .in_timestamp (in_timestamp),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cd_count     (cd_count),
        .th_count     (th_count),
        .debug_state  (debug_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    bit          rand_bp  = 1'b0;
    int          acc_wait = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_w[$];
    int          obs_cyc[$];
    int          exp_th   = 0;
    int          exp_cd   = 0;
    bit          m_seen   = 1'b0;
    longint      m_last   = 0;
    logic [31:0] mon_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] obs_at(input int i);
        if (i < obs_w.size()) return obs_w[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Reference model: one TIME_HIGH whenever ts/64 differs from the last one sent, then the CD word.
    task automatic model_push(input int x, input int y, input int p, input longint ts);
        longint hi = ts / 64;
        longint lo = ts % 64;
        if (!m_seen || hi != m_last) begin
            exp_q.push_back(32'h8000_0000 | 32'(hi));
            m_seen = 1'b1;
            m_last = hi;
        end
        exp_q.push_back(32'((longint'(p) << 28) | (lo << 22) | (longint'(x) << 11) | longint'(y)));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_seen = 1'b0;
        m_last = 0;
        exp_th = 0;
        exp_cd = 0;
    endtask

    // Output monitor: counters against the model counts, each transferred word against the queue.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check_eq("cd_count", 32'(cd_count), 32'(exp_cd % (1 << CNT_BITS)));
            check_eq("th_count", 32'(th_count), 32'(exp_th % (1 << CNT_BITS)));
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
                else mon_exp = ~out_word;
                check_eq("out_word", out_word, mon_exp);
                if (mon_exp[31:28] == 4'h8) exp_th++;
                else exp_cd++;
                obs_w.push_back(out_word);
                obs_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_event(input logic [10:0] x, input logic [10:0] y, input logic p,
                              input logic [33:0] ts);
        int w = 0;
        in_x = x; in_y = y; in_polarity = p; in_timestamp = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        acc_wait = w;
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        else model_push(int'(x), int'(y), int'(p), longint'(ts));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int     n0;
        int     stalls;
        longint cur;
        longint mask;

        rst_n = 1'b0; in_x = 11'd0; in_y = 11'd0; in_polarity = 1'b0;
        in_timestamp = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_word", out_word, 32'd0);
        check_eq("rst_state", 32'(debug_state), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // First event: TIME_HIGH then CD
        n0 = obs_w.size();
        send_event(11'd100, 11'd50, 1'b1, 34'h45);
        drain("t1_drain");
        check_eq("t1_th_word", obs_at(n0), 32'h8000_0001);
        check_eq("t1_cd_word", obs_at(n0 + 1), 32'h1143_2032);
        check_eq("t1_th_count", 32'(th_count), 32'd1);
        check_eq("t1_cd_count", 32'(cd_count), 32'd1);

        // Same upper bits: single CD word
        n0 = obs_w.size();
        send_event(11'd0, 11'd0, 1'b0, 34'h7F);
        drain("t2_drain");
        check_eq("t2_word", obs_at(n0), 32'h0FC0_0000);
        check_eq("t2_nwords", 32'(obs_w.size() - n0), 32'd1);
        check_eq("t2_th_count", 32'(th_count), 32'd1);

        // Eight events back to back
        n0 = obs_w.size();
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send_event(11'(i * 3), 11'(i * 5), 1'(i), 34'(34'h80 + i));
            if (i >= 2) stalls += acc_wait;
        end
        drain("t3_drain");
        check_eq("t3_nwords", 32'(obs_w.size() - n0), 32'd9);
        check_eq("t3_th_word", obs_at(n0), 32'h8000_0002);
        if (obs_cyc.size() >= n0 + 9)
            check_eq("t3_cd_span", 32'(obs_cyc[n0 + 8] - obs_cyc[n0 + 1]), 32'd7);
        check_eq("t3_stalls", 32'(stalls), 32'd0);

        // Backpressure on a pending CD word
        out_ready = 1'b0;
        n0 = exp_cd;
        send_event(11'd7, 11'd9, 1'b1, 34'h88);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_word", out_word, 32'h1200_3809);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_cd_count", 32'(cd_count), 32'(n0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("bp_transfer", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check_eq("bp_cd_after", 32'(cd_count), 32'(n0 + 1));

        // Reset while a TIME_HIGH is pending
        out_ready = 1'b0;
        send_event(11'd1, 11'd2, 1'b0, 34'h1_0000);
        @(negedge clk);
        check_eq("rs_state_th", 32'(debug_state), 32'd1);
        check_eq("rs_word_th", out_word, 32'h8000_0400);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rs_out_valid", 32'(out_valid), 32'd0);
        check_eq("rs_cd_count", 32'(cd_count), 32'd0);
        check_eq("rs_th_count", 32'(th_count), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rs_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        n0 = obs_w.size();
        send_event(11'd1, 11'd2, 1'b0, 34'h1_0005);
        drain("rs_drain");
        check_eq("rs_th_again", obs_at(n0), 32'h8000_0400);
        check_eq("rs_cd_word", obs_at(n0 + 1), 32'h0140_0802);

        // Randomized events with random backpressure
        mask = (longint'(1) << 34) - 1;
        cur = 0;
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: cur = cur + longint'($urandom_range(0, 20));
                6, 7:             cur = cur + longint'($urandom_range(64, 400));
                8:                cur = (cur >= 200) ? cur - longint'($urandom_range(0, 200)) : cur;
                default:          cur = (longint'($urandom_range(0, 3)) << 32) | longint'($urandom);
            endcase
            cur = cur & mask;
            send_event(11'($urandom), 11'($urandom), 1'($urandom), 34'(cur));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("rand_drain");

        // Keep-alive behaviour after a single event
        reset_pulse();
        n0 = obs_w.size();
        send_event(11'd100, 11'd50, 1'b1, 34'h45);
`ifdef EVT2_ENC_HEARTBEAT_EN
        exp_q.push_back(32'h8000_0000 | 32'(m_last));
        drain("hb_drain");
        check_eq("hb_word", obs_at(n0 + 2), 32'h8000_0001);
        check_eq("hb_th_count", 32'(th_count), 32'd2);
`else
        drain("hb_drain");
        n0 = obs_w.size();
        repeat (100) @(negedge clk);
        check_eq("hb_none_words", 32'(obs_w.size() - n0), 32'd0);
        check_eq("hb_none_valid", 32'(out_valid), 32'd0);
        check_eq("hb_none_th", 32'(th_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
